// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and the channel-select width helper for the clock divider
package clkdiv_pkg;
  localparam int DIV_W_DEF = 16;
  localparam int MAX_CH = 16;
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/multichannel_clock_divider_if.sv
// multichannel_clock_divider_if: config handshake, sync strobe and per-channel outputs
interface multichannel_clock_divider_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int CH_W = ch_width(NUM_CH)
);
  logic cfg_valid, cfg_ready, cfg_err, sync;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [NUM_CH-1:0] pending, tick, div_out;
  modport master(output cfg_valid, cfg_ch, cfg_div, sync, input cfg_ready, cfg_err, pending, tick, div_out);
  modport slave(input cfg_valid, cfg_ch, cfg_div, sync, output cfg_ready, cfg_err, pending, tick, div_out);
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider with active/shadow divisor; outputs are computed from next-cycle state
module clkdiv_channel #(
  parameter int DIV_W = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_sync,
  output logic             o_pending,
  output logic             o_tick,
  output logic             o_div_out
);
  logic [DIV_W-1:0] r_cnt, r_div, r_shadow;
  logic r_pend, r_tick, r_out;
  logic w_wrap, w_apply;
  logic [DIV_W-1:0] w_nd, w_nc;
  logic [DIV_W:0] w_half;
  always_comb begin
    w_wrap = (r_div != '0) && (r_cnt + DIV_W'(1) == r_div);
    w_apply = r_pend && (i_sync || r_div == '0 || w_wrap);
    w_nd = w_apply ? r_shadow : r_div;
    w_nc = (i_sync || w_wrap || r_div == '0) ? '0 : r_cnt + DIV_W'(1);
    w_half = ({1'b0, w_nd} + (DIV_W+1)'(1)) >> 1;
  end
  // a write landing on the applying edge keeps the new value pending
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_div <= DIV_W'(DEFAULT_DIV);
      r_shadow <= DIV_W'(DEFAULT_DIV);
      r_pend <= 1'b0;
      r_tick <= 1'b0;
      r_out <= 1'b0;
    end else begin
      r_cnt <= w_nc;
      r_div <= w_nd;
      r_shadow <= i_wr ? i_div : r_shadow;
      r_pend <= i_wr || (r_pend && !w_apply);
      r_tick <= i_sync ? (w_nd == DIV_W'(1)) : w_wrap;
      r_out <= (w_nd != '0) && ({1'b0, w_nc} < w_half);
    end
  assign o_pending = r_pend;
  assign o_tick = r_tick;
  assign o_div_out = r_out;
endmodule

// File: rtl/multichannel_clock_divider.sv
// multichannel_clock_divider: NUM_CH programmable clock-enable dividers sharing one config port and sync
module multichannel_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 16
) (
  input logic clk,
  input logic reset,
  multichannel_clock_divider_if.slave bus
);
  localparam int CH_W = ch_width(NUM_CH);
  logic r_ready, r_err;
  logic w_acc, w_ok;
  assign w_acc = bus.cfg_valid && r_ready;
  assign w_ok = {1'b0, bus.cfg_ch} < (CH_W+1)'(NUM_CH);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ready <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err <= w_acc && !w_ok;
    end
  assign bus.cfg_ready = r_ready;
  assign bus.cfg_err = r_err;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk(clk),
      .reset(reset),
      .i_wr(w_acc && w_ok && bus.cfg_ch == CH_W'(i)),
      .i_div(bus.cfg_div),
      .i_sync(bus.sync),
      .o_pending(bus.pending[i]),
      .o_tick(bus.tick[i]),
      .o_div_out(bus.div_out[i])
    );
  end
endmodule

// File: tb/tb_multichannel_clock_divider.sv
// tb_multichannel_clock_divider: directed scenario tasks; second instance has NUM_CH=5 so cfg_ch can be out of range
module tb_multichannel_clock_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  multichannel_clock_divider_if #(.NUM_CH(4), .DIV_W(16)) bus0();
  multichannel_clock_divider_if #(.NUM_CH(5), .DIV_W(16)) bus1();
  multichannel_clock_divider #(.NUM_CH(4), .DIV_W(16), .DEFAULT_DIV(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  multichannel_clock_divider #(.NUM_CH(5), .DIV_W(16), .DEFAULT_DIV(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic tk(input bit b, input int ch);
    return b ? bus1.tick[ch] : bus0.tick[ch];
  endfunction
  function automatic int dv(input bit b, input int ch);
    return b ? int'(bus1.div_out[ch]) : int'(bus0.div_out[ch]);
  endfunction
  // period = cycles between ticks, hi = div_out-high cycles in that period; 0/0 on timeout
  task automatic measure(input bit b, input int ch, output int per, output int hi);
    int w = 0;
    per = 0;
    hi = 0;
    while (!tk(b, ch) && w < 100) begin step(); w++; end
    if (tk(b, ch)) begin
      do begin hi += dv(b, ch); per++; step(); end while (!tk(b, ch) && per < 100);
    end
  endtask
  task automatic test_reset();
    int per, hi;
    reset = 1'b1;
    repeat (3) step();
    checks++; if (bus0.tick !== 4'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0000", bus0.tick); end
    checks++; if (bus0.div_out !== 4'b0) begin errors++; $display("FAIL rst_div_out: got %b expected 0000", bus0.div_out); end
    checks++; if (bus0.pending !== 4'b0) begin errors++; $display("FAIL rst_pending: got %b expected 0000", bus0.pending); end
    checks++; if (bus0.cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus0.cfg_ready); end
    checks++; if (bus0.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus0.cfg_err); end
    reset = 1'b0;
    step();
    checks++; if (bus0.cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b expected 1", bus0.cfg_ready); end
    checks++; if (bus0.div_out !== 4'b1111) begin errors++; $display("FAIL first_div_out: got %b expected 1111", bus0.div_out); end
    repeat (14) step();
    checks++; if (bus0.tick !== 4'b0) begin errors++; $display("FAIL no_early_tick: got %b expected 0000", bus0.tick); end
    step();
    checks++; if (bus0.tick !== 4'b1111) begin errors++; $display("FAIL first_tick: got %b expected 1111", bus0.tick); end
    measure(0, 0, per, hi);
    checks++; if (per !== 16) begin errors++; $display("FAIL def_period: got %0d expected 16", per); end
    checks++; if (hi !== 8) begin errors++; $display("FAIL def_high: got %0d expected 8", hi); end
  endtask
  task automatic test_ch1_div5();
    int per, hi;
    repeat (4) step();
    bus0.cfg_valid = 1'b1; bus0.cfg_ch = 2'd1; bus0.cfg_div = 16'd5;
    step();
    bus0.cfg_valid = 1'b0;
    checks++; if (bus0.pending !== 4'b0010) begin errors++; $display("FAIL ch1_pend_set: got %b expected 0010", bus0.pending); end
    checks++; if (bus0.cfg_err !== 1'b0) begin errors++; $display("FAIL ch1_no_err: got %b expected 0", bus0.cfg_err); end
    repeat (10) step();
    checks++; if (bus0.pending[1] !== 1'b1) begin errors++; $display("FAIL ch1_pend_hold: got %b expected 1", bus0.pending[1]); end
    step();
    checks++; if (bus0.pending[1] !== 1'b0) begin errors++; $display("FAIL ch1_pend_clr: got %b expected 0", bus0.pending[1]); end
    checks++; if (bus0.tick[1] !== 1'b1) begin errors++; $display("FAIL ch1_wrap_tick: got %b expected 1", bus0.tick[1]); end
    measure(0, 1, per, hi);
    checks++; if (per !== 5) begin errors++; $display("FAIL ch1_period: got %0d expected 5", per); end
    checks++; if (hi !== 3) begin errors++; $display("FAIL ch1_high: got %0d expected 3", hi); end
  endtask
  task automatic test_ch2_div0_div1();
    int w, cnt;
    bus0.cfg_valid = 1'b1; bus0.cfg_ch = 2'd2; bus0.cfg_div = 16'd0;
    step();
    bus0.cfg_valid = 1'b0;
    checks++; if (bus0.pending[2] !== 1'b1) begin errors++; $display("FAIL ch2_pend0: got %b expected 1", bus0.pending[2]); end
    w = 0;
    do begin step(); w++; end while (!bus0.tick[2] && w < 40);
    checks++; if (bus0.tick[2] !== 1'b1) begin errors++; $display("FAIL ch2_wrap: got %b expected 1 within 40 cycles", bus0.tick[2]); end
    checks++; if (bus0.pending[2] !== 1'b0) begin errors++; $display("FAIL ch2_applied0: got %b expected 0", bus0.pending[2]); end
    cnt = 0;
    repeat (20) begin step(); cnt += int'(bus0.tick[2]) + int'(bus0.div_out[2]); end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL ch2_disabled: got %0d active samples expected 0", cnt); end
    bus0.cfg_valid = 1'b1; bus0.cfg_div = 16'd1;
    step();
    bus0.cfg_valid = 1'b0;
    checks++; if (bus0.pending[2] !== 1'b1) begin errors++; $display("FAIL ch2_pend1: got %b expected 1", bus0.pending[2]); end
    step();
    checks++; if (bus0.pending[2] !== 1'b0) begin errors++; $display("FAIL ch2_applied1: got %b expected 0", bus0.pending[2]); end
    checks++; if (bus0.div_out[2] !== 1'b1) begin errors++; $display("FAIL ch2_out1: got %b expected 1", bus0.div_out[2]); end
    cnt = 0;
    repeat (8) begin step(); cnt += int'(bus0.tick[2] & bus0.div_out[2]); end
    checks++; if (cnt !== 8) begin errors++; $display("FAIL ch2_held1: got %0d expected 8", cnt); end
  endtask
  task automatic test_sync();
    int per, hi;
    bus0.cfg_valid = 1'b1; bus0.cfg_ch = 2'd3; bus0.cfg_div = 16'd7;
    step();
    checks++; if (bus0.pending !== 4'b1000) begin errors++; $display("FAIL ch3_pend: got %b expected 1000", bus0.pending); end
    bus0.cfg_ch = 2'd0; bus0.cfg_div = 16'd3; bus0.sync = 1'b1;
    step();
    bus0.cfg_valid = 1'b0; bus0.sync = 1'b0;
    checks++; if (bus0.div_out !== 4'b1111) begin errors++; $display("FAIL sync_out: got %b expected 1111", bus0.div_out); end
    checks++; if (bus0.tick !== 4'b0100) begin errors++; $display("FAIL sync_tick: got %b expected 0100", bus0.tick); end
    checks++; if (bus0.pending !== 4'b0001) begin errors++; $display("FAIL sync_pend: got %b expected 0001", bus0.pending); end
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 6) begin checks++; if (bus0.tick[3] !== 1'b0) begin errors++; $display("FAIL ch3_early: got %b expected 0", bus0.tick[3]); end end
      if (k == 7) begin checks++; if (bus0.tick[3] !== 1'b1) begin errors++; $display("FAIL ch3_tick7: got %b expected 1", bus0.tick[3]); end end
      if (k == 15) begin checks++; if (bus0.pending[0] !== 1'b1) begin errors++; $display("FAIL ch0_pend_hold: got %b expected 1", bus0.pending[0]); end end
      if (k == 16) begin checks++; if ({bus0.pending[0], bus0.tick[0]} !== 2'b01) begin errors++; $display("FAIL ch0_apply: got pend/tick %b expected 01", {bus0.pending[0], bus0.tick[0]}); end end
    end
    measure(0, 0, per, hi);
    checks++; if (per !== 3 || hi !== 2) begin errors++; $display("FAIL ch0_div3: got %0d/%0d expected 3/2", per, hi); end
    measure(0, 3, per, hi);
    checks++; if (per !== 7 || hi !== 4) begin errors++; $display("FAIL ch3_div7: got %0d/%0d expected 7/4", per, hi); end
    measure(0, 1, per, hi);
    checks++; if (per !== 5 || hi !== 3) begin errors++; $display("FAIL ch1_after_sync: got %0d/%0d expected 5/3", per, hi); end
  endtask
  task automatic test_cfg_err();
    int per, hi;
    bus1.cfg_valid = 1'b1; bus1.cfg_ch = 3'd5; bus1.cfg_div = 16'd9;
    step();
    bus1.cfg_valid = 1'b0;
    checks++; if (bus1.cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", bus1.cfg_err); end
    checks++; if (bus1.pending !== 5'b0) begin errors++; $display("FAIL err_no_pend: got %b expected 00000", bus1.pending); end
    step();
    checks++; if (bus1.cfg_err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b expected 0", bus1.cfg_err); end
    bus1.cfg_valid = 1'b1; bus1.cfg_ch = 3'd4;
    step();
    bus1.cfg_valid = 1'b0;
    checks++; if (bus1.cfg_err !== 1'b0) begin errors++; $display("FAIL err_valid_ch: got %b expected 0", bus1.cfg_err); end
    checks++; if (bus1.pending !== 5'b10000) begin errors++; $display("FAIL ch4_pend: got %b expected 10000", bus1.pending); end
    measure(1, 0, per, hi);
    checks++; if (per !== 16 || hi !== 8) begin errors++; $display("FAIL err_period: got %0d/%0d expected 16/8", per, hi); end
  endtask
  task automatic test_reset_mid();
    int per, hi;
    bus0.cfg_valid = 1'b1; bus0.cfg_ch = 2'd1; bus0.cfg_div = 16'd9;
    step();
    bus0.cfg_valid = 1'b0;
    checks++; if (bus0.pending[1] !== 1'b1) begin errors++; $display("FAIL mid_pend: got %b expected 1", bus0.pending[1]); end
    repeat (2) step();
    reset = 1'b1;
    #1;
    checks++; if ({bus0.tick, bus0.div_out, bus0.pending} !== 12'b0) begin errors++; $display("FAIL async_clear: got %b expected all 0", {bus0.tick, bus0.div_out, bus0.pending}); end
    checks++; if (bus0.cfg_ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", bus0.cfg_ready); end
    step();
    reset = 1'b0;
    step();
    checks++; if (bus0.cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus0.cfg_ready); end
    repeat (14) step();
    checks++; if (bus0.tick !== 4'b0) begin errors++; $display("FAIL mid_no_tick: got %b expected 0000", bus0.tick); end
    step();
    checks++; if (bus0.tick !== 4'b1111 || bus0.pending !== 4'b0) begin errors++; $display("FAIL mid_resume: got tick %b pend %b expected 1111 0000", bus0.tick, bus0.pending); end
    measure(0, 1, per, hi);
    checks++; if (per !== 16 || hi !== 8) begin errors++; $display("FAIL mid_default: got %0d/%0d expected 16/8", per, hi); end
  endtask
  initial begin
    bus0.cfg_valid = 1'b0; bus0.cfg_ch = '0; bus0.cfg_div = '0; bus0.sync = 1'b0;
    bus1.cfg_valid = 1'b0; bus1.cfg_ch = '0; bus1.cfg_div = '0; bus1.sync = 1'b0;
    test_reset();
    test_ch1_div5();
    test_ch2_div0_div1();
    test_sync();
    test_cfg_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
